sys_array_ctrl: RTL and testbench

Sequencer for an ARRAY_N x ARRAY_N weight-stationary systolic array built from sys_array_cell instances. Inputs flow horizontally and partial sums flow vertically.
On a start command it runs three phases in order:
- Load weights row by row from the weight buffer.
- Stream num_vec input vectors from the input buffer, with per-row skew enables.
- Emit column-valid and result-write strobes, then pulse done.
It sits between the host command interface, the weight/input/result buffers and the array's control pins.

---
 rtl/sys_array_pkg.sv | 21 ++
 rtl/sys_array_ctrl_if.sv | 56 +++++
 rtl/sys_array_skew_pipe.sv | 43 ++++
 rtl/sys_array_ctrl.sv | 134 +++++++++++++
 tb/tb_sys_array_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic-array sequencer.
package sys_array_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWLoad,
      StWWait,
      StFeed,
      StDrain,
      StDone
   } ctrl_state_t;

   localparam int unsigned DEF_ARRAY_N    = 4;
   localparam int unsigned DEF_DATA_WIDTH = 16;

   // Stages from the first row's feed to the deskewed result strobe.
   function automatic int unsigned skew_depth(input int unsigned n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/sys_array_ctrl_if.sv
// Command, buffer and array-control signals of the systolic-array sequencer.
interface sys_array_ctrl_if
   import sys_array_pkg::*;
#(
   parameter int unsigned ARRAY_N = DEF_ARRAY_N,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned ROW_W   = $clog2(ARRAY_N)
);

   logic               start;
   logic [CNT_W-1:0]   num_vec;
   logic               busy;
   logic               done;
   logic               w_rd_en;
   logic [ROW_W-1:0]   w_rd_addr;
   logic [ARRAY_N-1:0] weight_load_row;
   logic               in_rd_en;
   logic [CNT_W-1:0]   in_rd_addr;
   logic [ARRAY_N-1:0] feed_en;
   logic [ARRAY_N-1:0] col_valid;
   logic               res_wr_en;
   logic [CNT_W-1:0]   res_wr_addr;

   modport master (
      output start,
      output num_vec,
      input  busy,
      input  done,
      input  w_rd_en,
      input  w_rd_addr,
      input  weight_load_row,
      input  in_rd_en,
      input  in_rd_addr,
      input  feed_en,
      input  col_valid,
      input  res_wr_en,
      input  res_wr_addr
   );

   modport slave (
      input  start,
      input  num_vec,
      output busy,
      output done,
      output w_rd_en,
      output w_rd_addr,
      output weight_load_row,
      output in_rd_en,
      output in_rd_addr,
      output feed_en,
      output col_valid,
      output res_wr_en,
      output res_wr_addr
   );

endinterface

// File: rtl/sys_array_skew_pipe.sv
// Valid pipeline turning the input-read strobe into per-row feed enables,
// per-column valids and the deskewed result-write strobe.
module sys_array_skew_pipe
   import sys_array_pkg::*;
#(
   parameter int unsigned ARRAY_N = DEF_ARRAY_N
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_rd_en,
   output logic [ARRAY_N-1:0] feed_en,
   output logic [ARRAY_N-1:0] col_valid,
   output logic               res_wr_en,
   output logic               pending
);

   localparam int unsigned Depth = skew_depth(ARRAY_N);

   // in_vld_q marks the cycle buffer data is present (read latency 1).
   logic             in_vld_q;
   logic [Depth-1:0] sr_q;
   logic [Depth-1:0] sr_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         in_vld_q <= 1'b0;
         sr_q     <= '0;
      end else begin
         in_vld_q <= in_rd_en;
         sr_q     <= sr_d;
      end
   end

   always_comb begin
      sr_d      = {sr_q[Depth-2:0], in_vld_q};
      feed_en   = {sr_q[ARRAY_N-2:0], in_vld_q};
      col_valid = sr_q[Depth-1:ARRAY_N-1];
      res_wr_en = sr_q[Depth-1];
      // The final stage is excluded: its strobe is issued in the same cycle.
      pending   = in_vld_q | (|sr_q[Depth-2:0]);
   end

endmodule

// File: rtl/sys_array_ctrl.sv
// Sequencer for a weight-stationary systolic array: weight load, input
// streaming with row skew, then result strobes and a done pulse.
module sys_array_ctrl
   import sys_array_pkg::*;
#(
   parameter int unsigned ARRAY_N = DEF_ARRAY_N,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned ROW_W   = $clog2(ARRAY_N)
) (
   input logic             clk,
   input logic             reset_n,
   sys_array_ctrl_if.slave bus
);

   localparam logic [ROW_W-1:0] LastRow = ROW_W'(ARRAY_N - 1);

   ctrl_state_t        state_q, state_d;
   logic [CNT_W-1:0]   m_q, m_d;
   logic [CNT_W-1:0]   vec_q, vec_d;
   logic [CNT_W-1:0]   res_q, res_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [ARRAY_N-1:0] wl_row_q, wl_row_d;

   logic               w_rd_en;
   logic               in_rd_en;
   logic               done_pulse;
   logic               pipe_pending;
   logic               res_wr_en;
   logic [ARRAY_N-1:0] feed_en;
   logic [ARRAY_N-1:0] col_valid;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         m_q      <= '0;
         vec_q    <= '0;
         res_q    <= '0;
         row_q    <= '0;
         wl_row_q <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         vec_q    <= vec_d;
         res_q    <= res_d;
         row_q    <= row_d;
         wl_row_q <= wl_row_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      vec_d      = vec_q;
      row_d      = row_q;
      res_d      = res_wr_en ? res_q + CNT_W'(1) : res_q;
      w_rd_en    = 1'b0;
      in_rd_en   = 1'b0;
      done_pulse = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               m_d     = bus.num_vec;
               vec_d   = '0;
               row_d   = '0;
               res_d   = '0;
               state_d = StWLoad;
            end
         end
         StWLoad: begin
            w_rd_en = 1'b1;
            row_d   = row_q + ROW_W'(1);
            if (row_q == LastRow) begin
               state_d = StWWait;
            end
         end
         StWWait: begin
            // Last weight row is being written; an empty job skips compute.
            state_d = (m_q == '0) ? StDone : StFeed;
         end
         StFeed: begin
            in_rd_en = 1'b1;
            if (vec_q == m_q - CNT_W'(1)) begin
               vec_d   = '0;
               state_d = StDrain;
            end else begin
               vec_d = vec_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (!pipe_pending) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done_pulse = 1'b1;
            res_d      = '0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Row strobe lags the read by one cycle to line up with buffer data.
   always_comb begin
      wl_row_d = w_rd_en ? (ARRAY_N'(1) << row_q) : '0;
   end

   sys_array_skew_pipe #(
      .ARRAY_N (ARRAY_N)
   ) u_skew_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_rd_en  (in_rd_en),
      .feed_en   (feed_en),
      .col_valid (col_valid),
      .res_wr_en (res_wr_en),
      .pending   (pipe_pending)
   );

   always_comb begin
      bus.busy            = (state_q != StIdle);
      bus.done            = done_pulse;
      bus.w_rd_en         = w_rd_en;
      bus.w_rd_addr       = row_q;
      bus.weight_load_row = wl_row_q;
      bus.in_rd_en        = in_rd_en;
      bus.in_rd_addr      = vec_q;
      bus.feed_en         = feed_en;
      bus.col_valid       = col_valid;
      bus.res_wr_en       = res_wr_en;
      bus.res_wr_addr     = res_q;
   end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench: cycle-level timing model of the sequencer plus a 4x4
// weight-stationary array model checking end-to-end results.
module tb_sys_array_ctrl;

   localparam int N  = 4;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset_n;

   sys_array_ctrl_if #(.ARRAY_N(N), .CNT_W(CW)) bus ();

   sys_array_ctrl #(
      .ARRAY_N (N),
      .CNT_W   (CW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, $signed(act), $signed(exp));
      end
   endtask

   // ---------------- timing model: outputs as a function of job-relative cycle
   bit job_v = 1'b0;
   int job_s = 0;
   int job_m = 0;

   always @(negedge clk) begin
      int rel, dn, k;
      logic e_busy, e_done, e_w, e_in, e_res;
      logic [N-1:0] e_wlr, e_feed, e_col;
      rel    = cyc - job_s;
      dn     = (job_m > 0) ? 3 * N + job_m + 2 : N + 2;
      e_busy = job_v && rel >= 1 && rel <= dn;
      e_done = job_v && rel == dn;
      e_w    = job_v && rel >= 1 && rel <= N;
      e_wlr  = (job_v && rel >= 2 && rel <= N + 1) ? (N'(1) << (rel - 2)) : '0;
      e_in   = job_v && rel >= N + 2 && rel <= N + 1 + job_m;
      for (int r = 0; r < N; r++) begin
         k = rel - (N + 3) - r;
         e_feed[r] = job_v && k >= 0 && k < job_m;
         k = rel - (2 * N + 3) - r;
         e_col[r] = job_v && k >= 0 && k < job_m;
      end
      k     = rel - (3 * N + 2);
      e_res = job_v && k >= 0 && k < job_m;
      if (chk_en) begin
         chk("busy", bus.busy, e_busy);
         chk("done", bus.done, e_done);
         chk("w_rd_en", bus.w_rd_en, e_w);
         if (e_w) chk("w_rd_addr", bus.w_rd_addr, rel - 1);
         chk("weight_load_row", bus.weight_load_row, e_wlr);
         chk("in_rd_en", bus.in_rd_en, e_in);
         if (e_in) chk("in_rd_addr", bus.in_rd_addr, rel - N - 2);
         chk("feed_en", bus.feed_en, e_feed);
         chk("col_valid", bus.col_valid, e_col);
         chk("res_wr_en", bus.res_wr_en, e_res);
         if (e_res) chk("res_wr_addr", bus.res_wr_addr, k);
      end
      if (!reset_n) begin
         job_v = 1'b0;
      end else if (bus.start && (!job_v || rel > dn)) begin
         job_v = 1'b1;
         job_s = cyc;
         job_m = int'(bus.num_vec);
      end
   end

   // ---------------- buffers and array model driven by the DUT's control pins
   int wbuf    [0:N-1][0:N-1];
   int ibuf    [0:255][0:N-1];
   int res_mem [0:7][0:N-1];
   int e2e_exp [0:2][0:N-1];

   int w_dq [0:N-1];
   int in_q [0:N-1];
   int hist [0:N-1][0:N-1];
   int bh   [0:N-1][0:N-1];
   int wt   [0:N-1][0:N-1];
   int a_q  [0:N-1][0:N-1];
   int p_q  [0:N-1][0:N-1];

   always @(negedge clk) begin
      int a_n [0:N-1][0:N-1];
      int p_n [0:N-1][0:N-1];
      int x;
      hist[0] = in_q;
      bh[0]   = p_q[N-1];
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (c == 0) x = (bus.feed_en[r] === 1'b1) ? hist[r][r] : 0;
            else        x = a_q[r][c-1];
            a_n[r][c] = x;
            p_n[r][c] = ((r == 0) ? 0 : p_q[r-1][c]) + wt[r][c] * x;
         end
      end
      if (bus.res_wr_en === 1'b1) begin
         for (int c = 0; c < N; c++) res_mem[bus.res_wr_addr[2:0]][c] = bh[N-1-c][c];
      end
      for (int d = N - 1; d > 0; d--) begin
         hist[d] = hist[d-1];
         bh[d]   = bh[d-1];
      end
      for (int r = 0; r < N; r++) begin
         if (bus.weight_load_row[r] === 1'b1) wt[r] = w_dq;
      end
      if (bus.w_rd_en === 1'b1) w_dq = wbuf[bus.w_rd_addr];
      if (bus.in_rd_en === 1'b1) in_q = ibuf[bus.in_rd_addr];
      a_q = a_n;
      p_q = p_n;
   end

   // ---------------- directed stimulus
   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic e2e(input string tag, input int nv);
      for (int v = 0; v < nv; v++) begin
         for (int c = 0; c < N; c++) begin
            chk($sformatf("e2e_%s_v%0d_c%0d", tag, v, c), res_mem[v][c], e2e_exp[v][c]);
         end
      end
   endtask

   localparam int SA = 10;
   localparam int SB = SA + 18;
   localparam int SC = 50;
   localparam int SD = 60;
   localparam int SE = SD + 12;

   initial begin
      reset_n     = 1'b0;
      bus.start   = 1'b0;
      bus.num_vec = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) wbuf[r][c] = (r == c) ? 2 : 0;
      end
      ibuf[0] = '{1, 2, 3, 4};
      ibuf[1] = '{-1, 0, 5, 7};
      ibuf[2] = '{9, -3, 0, 1};
      e2e_exp = '{'{2, 4, 6, 8}, '{-2, 0, 10, 14}, '{18, -6, 0, 2}};

      goto(3);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      goto(8);
      @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      chk("idle_strobes", {bus.done, bus.w_rd_en, bus.in_rd_en, bus.res_wr_en}, 0);

      // Job A: M=3, with ignored starts in FEED and DONE.
      goto(SA);
      bus.start = 1'b1; bus.num_vec = 8'd3;
      goto(SA + 1);
      bus.start = 1'b0; bus.num_vec = '0;
      goto(SA + 5);
      @(negedge clk);
      chk("lit_wlr_last", bus.weight_load_row, 4'b1000);
      goto(SA + 7);
      bus.start = 1'b1; bus.num_vec = 8'd9;
      @(negedge clk);
      chk("lit_in_addr1", bus.in_rd_addr, 1);
      chk("lit_feed_c7", bus.feed_en, 4'b0001);
      goto(SA + 8);
      bus.start = 1'b0; bus.num_vec = '0;
      goto(SA + 10);
      @(negedge clk);
      chk("lit_feed_c10", bus.feed_en, 4'b1110);
      goto(SA + 14);
      @(negedge clk);
      chk("lit_col_c14", bus.col_valid, 4'b1110);
      chk("lit_res_c14", {bus.res_wr_en, bus.res_wr_addr}, {1'b1, 8'd0});
      goto(SA + 17);
      bus.start = 1'b1; bus.num_vec = 8'd3;
      @(negedge clk);
      chk("lit_done_c17", bus.done, 1);
      goto(SB);
      @(negedge clk);
      chk("lit_busy_c18", bus.busy, 0);
      e2e("a", 3);

      // Job B launched at SA+18 runs with identical timing.
      goto(SB + 1);
      bus.start = 1'b0; bus.num_vec = '0;
      goto(SB + 17);
      @(negedge clk);
      chk("lit_done_b", bus.done, 1);
      goto(SB + 18);
      @(negedge clk);
      e2e("b", 3);

      // Job C: empty job.
      goto(SC);
      bus.start = 1'b1; bus.num_vec = '0;
      goto(SC + 1);
      bus.start = 1'b0;
      goto(SC + 6);
      @(negedge clk);
      chk("lit_done_m0", bus.done, 1);

      // Job D aborted by reset; job E restarts cleanly.
      goto(SD);
      bus.start = 1'b1; bus.num_vec = 8'd3;
      goto(SD + 1);
      bus.start = 1'b0;
      goto(SD + 9);
      reset_n = 1'b0;
      goto(SD + 10);
      reset_n = 1'b1;
      @(negedge clk);
      chk("lit_abort_busy", bus.busy, 0);
      chk("lit_abort_feed", bus.feed_en, 0);
      goto(SE);
      bus.start = 1'b1; bus.num_vec = 8'd2;
      goto(SE + 1);
      bus.start = 1'b0; bus.num_vec = '0;
      goto(SE + 16);
      @(negedge clk);
      chk("lit_done_e", bus.done, 1);
      goto(SE + 17);
      @(negedge clk);
      e2e("e", 2);

      goto(SE + 22);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
